// File: rtl/rans_encoder_pkg.sv
// Shared types and elaboration helpers for the rANS encoder slice.
package rans_encoder_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RENORM,
    DIV,
    UPDATE,
    FLUSH
  } rans_state_e;

  // Number of digits needed to flush a full coder state.
  function automatic int digit_count(int state_width, int digit_width);
    return (state_width + digit_width - 1) / digit_width;
  endfunction

  // The renormalisation bound f << DIGIT_WIDTH must fit inside the state.
  function automatic bit width_ok(int state_width, int cnt_width, int digit_width);
    return (digit_width > 0) && (state_width >= cnt_width + digit_width);
  endfunction

endpackage

// File: rtl/rans_encoder_if.sv
// Symbol-in / digit-out handshake bundle; master drives symbols and out_rdy, slave is the encoder.
interface rans_encoder_if #(
  parameter int STATE_WIDTH = 16,
  parameter int CNT_WIDTH   = 8,
  parameter int DIGIT_WIDTH = 4
);
  logic [CNT_WIDTH-1:0]   s_count;
  logic [STATE_WIDTH-1:0] s_cumulative;
  logic                   in_last;
  logic                   in_vld;
  logic                   in_rdy;
  logic [DIGIT_WIDTH-1:0] out;
  logic                   out_last;
  logic                   out_vld;
  logic                   out_rdy;

  modport master (
    output s_count, s_cumulative, in_last, in_vld, out_rdy,
    input  in_rdy, out, out_last, out_vld
  );

  modport slave (
    input  s_count, s_cumulative, in_last, in_vld, out_rdy,
    output in_rdy, out, out_last, out_vld
  );
endinterface

// File: rtl/rans_divider.sv
// Sequential restoring divider: one quotient bit per enabled cycle, N cycles after start.
// done flags the cycle whose closing edge writes the final bit; divide by zero yields all-ones q.
module rans_divider #(
  parameter int N = 16,
  parameter int D = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [D-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder
);
  localparam int CNTW = $clog2(N + 1);

  logic [N-1:0]    rem_q, quo_q, dvs_q;
  logic [CNTW-1:0] cnt_q;
  logic [N:0]      trial;
  logic            fits;

  // Shift the next dividend bit into the partial remainder and try a subtract.
  assign trial     = {rem_q, quo_q[N-1]};
  assign fits      = trial >= {1'b0, dvs_q};
  assign busy      = cnt_q != '0;
  assign done      = cnt_q == CNTW'(1);
  assign quotient  = quo_q;
  assign remainder = rem_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (ena) begin
      if (start) begin
        cnt_q <= CNTW'(N);
        rem_q <= '0;
        quo_q <= dividend;
        dvs_q <= N'(divisor);
      end else if (busy) begin
        cnt_q <= cnt_q - 1'b1;
        rem_q <= fits ? N'(trial - {1'b0, dvs_q}) : trial[N-1:0];
        quo_q <= {quo_q[N-2:0], fits};
      end
    end
  end
endmodule

// File: rtl/rans_encoder.sv
// Streaming rANS encoder: renormalise, divide (STATE_WIDTH cycles), update, optional flush; out holds under out_rdy=0.
// Define ANS_ENC_ERR_EN to reject f==0 or c+f>M with a one-cycle err pulse.
module rans_encoder
  import rans_encoder_pkg::*;
#(
  parameter int STATE_WIDTH = 16,
  parameter int CNT_WIDTH   = 8,
  parameter int DIGIT_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ena,
  input  logic [STATE_WIDTH-1:0] total_count,
  output logic                   err,
  rans_encoder_if.slave          bus
);
  localparam int DIGITS = digit_count(STATE_WIDTH, DIGIT_WIDTH);
  localparam int FW     = $clog2(DIGITS) + 1;
  localparam int CW     = STATE_WIDTH + CNT_WIDTH;

  if (!width_ok(STATE_WIDTH, CNT_WIDTH, DIGIT_WIDTH)) begin : g_bad_widths
    $error("rans_encoder: STATE_WIDTH must be >= CNT_WIDTH + DIGIT_WIDTH");
  end

  rans_state_e            state_q, state_d;
  logic [STATE_WIDTH-1:0] x_q, c_q, m_q, upd;
  logic [CNT_WIDTH-1:0]   f_q;
  logic                   last_q;
  logic [FW-1:0]          dig_q;
  logic                   accept, illegal, need_digit, out_vld_w, out_hs, dig_last;
  logic                   div_start, div_busy, div_done;
  logic [STATE_WIDTH-1:0] div_q, div_r;

  assign accept     = ena && bus.in_vld && (state_q == IDLE);
  assign need_digit = CW'(x_q) >= (CW'(f_q) << DIGIT_WIDTH);
  assign out_vld_w  = ((state_q == RENORM) && need_digit) || (state_q == FLUSH);
  assign out_hs     = ena && out_vld_w && bus.out_rdy;
  assign dig_last   = dig_q == FW'(DIGITS - 1);
  assign upd        = div_q * m_q + c_q + div_r;

  assign bus.in_rdy   = state_q == IDLE;
  assign bus.out_vld  = out_vld_w;
  assign bus.out      = out_vld_w ? x_q[DIGIT_WIDTH-1:0] : '0;
  assign bus.out_last = (state_q == FLUSH) && dig_last;

`ifdef ANS_ENC_ERR_EN
  logic [STATE_WIDTH:0] c_plus_f;
  logic                 err_q;
  assign c_plus_f = {1'b0, bus.s_cumulative} + (STATE_WIDTH + 1)'(bus.s_count);
  assign illegal  = (bus.s_count == '0) || (c_plus_f > {1'b0, total_count});
  always_ff @(posedge clk) begin
    if (rst)      err_q <= 1'b0;
    else if (ena) err_q <= accept && illegal;
  end
  assign err = err_q;
`else
  assign illegal = 1'b0;
  assign err     = 1'b0;
`endif

  rans_divider #(.N(STATE_WIDTH), .D(CNT_WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .start     (div_start),
    .dividend  (x_q),
    .divisor   (f_q),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  always_comb begin
    state_d   = state_q;
    div_start = 1'b0;
    case (state_q)
      IDLE:   if (accept) state_d = illegal ? (bus.in_last ? FLUSH : IDLE) : RENORM;
      RENORM: if (!need_digit && ena) begin
                div_start = 1'b1;
                state_d   = DIV;
              end
      // !div_busy only guards against a lost start; the normal exit is done.
      DIV:    if (ena && (div_done || !div_busy)) state_d = UPDATE;
      UPDATE: if (ena) state_d = last_q ? FLUSH : IDLE;
      FLUSH:  if (out_hs && dig_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= total_count;
      f_q     <= '0;
      c_q     <= '0;
      m_q     <= '0;
      last_q  <= 1'b0;
      dig_q   <= '0;
    end else if (ena) begin
      state_q <= state_d;
      if (accept && !illegal) begin
        f_q    <= bus.s_count;
        c_q    <= bus.s_cumulative;
        m_q    <= total_count;
        last_q <= bus.in_last;
      end
      if (out_hs) begin
        x_q <= ((state_q == FLUSH) && dig_last) ? total_count : (x_q >> DIGIT_WIDTH);
      end else if (state_q == UPDATE) begin
        x_q <= upd;
      end
      if (out_hs && (state_q == FLUSH)) dig_q <= dig_last ? '0 : dig_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_rans_encoder.sv
// Scoreboarded bench: an arithmetic rANS model queues expected digits at issue; a monitor checks each output handshake.
module tb_rans_encoder;
  localparam int SW = 16, CW = 8, DW = 4, DIGITS = 4;

  logic          clk = 1'b0;
  logic          rst, ena;
  logic [SW-1:0] total_count;
  logic          err;

  rans_encoder_if #(.STATE_WIDTH(SW), .CNT_WIDTH(CW), .DIGIT_WIDTH(DW)) bus ();

  rans_encoder #(.STATE_WIDTH(SW), .CNT_WIDTH(CW), .DIGIT_WIDTH(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .total_count (total_count),
    .err         (err),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] dig;
    logic          last;
  } exp_t;

  exp_t   exp_q[$];
  int     n_cmp = 0, n_bad = 0;
  longint mx;
  bit     ena_rand = 0, rdy_rand = 0, rdy_hold = 0, err_skip = 0;

  task automatic chk(string nm, longint act, longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endtask

  function automatic exp_t mk(longint d, bit l);
    exp_t e;
    e.dig  = DW'(d);
    e.last = l;
    return e;
  endfunction

  // Reference: textbook rANS with base 2^DW and state interval [M, M*2^DW).
  task automatic model_symbol(longint f, longint c, longint m, bit last);
    longint x = mx;
    bit bad = 0;
    longint base = longint'(1) << DW;
`ifdef ANS_ENC_ERR_EN
    bad = (f == 0) || (c + f > m);
`endif
    if (!bad) begin
      while (x >= f * base) begin
        exp_q.push_back(mk(x % base, 1'b0));
        x = x / base;
      end
      x = ((x / f) * m + c + (x % f)) % (longint'(1) << SW);
    end
    if (last) begin
      for (int i = 0; i < DIGITS; i++) exp_q.push_back(mk((x / (base ** i)) % base, i == DIGITS - 1));
      x = m;
    end
    mx = x;
  endtask

  task automatic send(int f, int c, bit last);
    int waited = 0;
    bit ok = 0;
    bus.s_count      = CW'(f);
    bus.s_cumulative = SW'(c);
    bus.in_last      = last;
    bus.in_vld       = 1'b1;
    while (!ok && waited < 3000) begin
      @(negedge clk);
      waited++;
      ok = ena && bus.in_rdy;
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: in_rdy never seen, f=%0d c=%0d", f, c);
    end else begin
      model_symbol(f, c, total_count, last);
    end
    @(posedge clk); #1;
    bus.in_vld = 1'b0;
  endtask

  task automatic wait_drain();
    int waited = 0;
    bit ok = 0;
    while (!ok && waited < 5000) begin
      @(negedge clk);
      waited++;
      ok = (exp_q.size() == 0) && bus.in_rdy;
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: %0d digits still expected", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset(int m);
    total_count = SW'(m);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mx  = m;
  endtask

  // ena / out_rdy driver, updated just after each rising edge.
  initial begin
    ena = 1'b1;
    bus.out_rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      ena         = ena_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.out_rdy = rdy_hold ? 1'b0 : (rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  // Monitor: pops the scoreboard on every output handshake and checks digit stability while stalled.
  initial begin
    logic [DW-1:0] hold_d;
    logic          hold_l;
    bit            holding = 0;
    exp_t          e;
    forever begin
      @(negedge clk);
      if (rst) begin
        holding = 0;
      end else begin
        if (!err_skip) chk("err_quiet", err, 0);
        if (holding) begin
          chk("hold_vld", bus.out_vld, 1);
          chk("hold_dig", bus.out, hold_d);
          chk("hold_last", bus.out_last, hold_l);
          holding = 0;
        end
        if (bus.out_vld && ena && bus.out_rdy) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_digit: got 0x%0h, expected no output", bus.out);
          end else begin
            e = exp_q.pop_front();
            chk("digit", bus.out, e.dig);
            chk("digit_last", bus.out_last, e.last);
          end
        end else if (bus.out_vld) begin
          holding = 1;
          hold_d  = bus.out;
          hold_l  = bus.out_last;
        end
      end
    end
  end

  initial begin
    int n, m, f, c, ns, waited;
    rst = 1'b1;
    total_count = SW'(16);
    bus.in_vld = 1'b0;
    bus.in_last = 1'b0;
    bus.s_count = '0;
    bus.s_cumulative = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_rdy", bus.in_rdy, 1);
    chk("rst_out_vld", bus.out_vld, 0);
    chk("rst_out", bus.out, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_err", err, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    mx  = 16;

    // First symbol: no renorm digit, in_rdy returns at the 19th edge after accept.
    send(4, 0, 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_rdy && n < 100);
    chk("accept_to_rdy", n, 19);
    @(posedge clk); #1;

    send(4, 4, 0);
    send(4, 4, 1);
    rdy_hold = 1;
    waited = 0;
    while (!bus.out_vld && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    chk("flush_started", bus.out_vld, 1);
    repeat (5) @(posedge clk);
    #1 rdy_hold = 0;
    wait_drain();
    send(4, 0, 1);
    wait_drain();

    // Abort partway through the divide.
    bus.s_count = CW'(4); bus.s_cumulative = '0; bus.in_last = 1'b1; bus.in_vld = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    bus.in_vld = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mx  = 16;
    @(negedge clk);
    chk("abort_in_rdy", bus.in_rdy, 1);
    chk("abort_out_vld", bus.out_vld, 0);
    @(posedge clk); #1;
    send(4, 4, 1);
    wait_drain();

`ifdef ANS_ENC_ERR_EN
    err_skip = 1;
    send(0, 0, 0);
    @(negedge clk);
    chk("err_pulse", err, 1);
    chk("err_in_rdy", bus.in_rdy, 1);
    chk("err_out_vld", bus.out_vld, 0);
    @(negedge clk);
    chk("err_clear", err, 0);
    err_skip = 0;
    @(posedge clk); #1;
    send(4, 0, 1);
    wait_drain();
`endif

    // Random streams, with and without ena / out_rdy throttling.
    for (int s = 0; s < 30; s++) begin
      m = $urandom_range(16, 4095);
      do_reset(m);
      ena_rand = (s % 3) == 1;
      rdy_rand = (s % 2) == 1;
      ns = $urandom_range(1, 6);
      for (int k = 0; k < ns; k++) begin
        f = $urandom_range(1, (m < 255) ? m : 255);
        c = $urandom_range(0, m - f);
        send(f, c, k == ns - 1);
      end
      wait_drain();
    end
    ena_rand = 0;
    rdy_rand = 0;
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rans_encoder.md
# rans_encoder

Parametrised streaming rANS encoder, the successor to the fixed-width ANS encoder. It accepts one symbol per handshake as (frequency, cumulative frequency) against a runtime total, renormalises by emitting DIGIT_WIDTH-bit digits LS-first, and updates the state with a multi-cycle restoring divider. On a stream-terminating symbol it flushes the full final state with an end marker. It sits between the symbol/frequency-table front end and the digit packer.

## Interface
- STATE_WIDTH, 16: coder state width; must be ≥ bits(total_count) + DIGIT_WIDTH.
- CNT_WIDTH, 8: width of s_count.
- DIGIT_WIDTH, 4: emitted digit width (renormalisation base 2^DIGIT_WIDTH).
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- ena  in  1  global enable; when low, FSM, state and all outputs hold.
- s_count  in  CNT_WIDTH  symbol frequency f.
- s_cumulative  in  STATE_WIDTH  cumulative frequency c.
- total_count  in  STATE_WIDTH  total M; held stable for a whole stream.
- in_last  in  1  marks the final symbol of a stream; triggers flush.
- in_vld  in  1  / in_rdy  out  1  input handshake.
- out  out  DIGIT_WIDTH  emitted digit.
- out_last  out  1  high with the final flush digit.
- out_vld  out  1  / out_rdy  in  1  output handshake.
- err  out  1  one-cycle pulse on an illegal symbol (ANS_ENC_ERR_EN only; else tied 0).

## Operation
- State x is valid in [M, M·2^DW). x = total_count on reset and after every flush.
- FSM states: IDLE, RENORM, DIV, UPDATE, FLUSH.
- IDLE: in_rdy=1. On ena&in_vld&in_rdy, latch f, c, M and in_last, then go to RENORM.
- RENORM: if x ≥ (f << DW), drive out=x[DW-1:0] with out_vld=1. On out handshake, x ← x >> DW and re-check the next cycle. Otherwise go to DIV.
- DIV: radix-2 restoring divide of x by f, one quotient bit per cycle, STATE_WIDTH cycles, producing q and r.
- UPDATE: x ← q·M + c + r, truncated to STATE_WIDTH (legal inputs never overflow). Go to FLUSH if the latched in_last is set, else IDLE.
- FLUSH: emit DIGITS = ceil(STATE_WIDTH/DW) digits of x, LS-first, one per out handshake; out_last=1 on the last digit. After the last handshake: x ← total_count, return to IDLE.
- Every digit output (RENORM or FLUSH) holds out/out_last stable while out_vld=1 and out_rdy=0.
- rst in any state: abort and return to IDLE. No partial digit survives.
- Outputs on reset: in_rdy=1, out_vld=0, out=0, out_last=0, err=0.

## Timing
- Accept at edge t: RENORM at t+1, DIV at t+2..t+STATE_WIDTH+1, UPDATE at t+STATE_WIDTH+2, in_rdy=1 at t+STATE_WIDTH+3 when no digit is emitted.
- Each emitted digit adds at least one cycle. A stalled out_rdy adds cycles one-for-one.
- in_rdy=1 only in IDLE, so input and output handshakes are never simultaneous.
- ena low freezes the current cycle, including partway through a divide. Handshakes complete only when ena=1.

## Configuration
- ANS_ENC_ERR_EN defined: on accept, if s_count==0 or s_cumulative+s_count > total_count, pulse err for one cycle, drop the symbol, leave x unchanged and stay in IDLE. If in_last is also set, the flush still runs.
- ANS_ENC_ERR_EN undefined: no check; err is constant 0; illegal inputs give undefined x but never hang the FSM (a divide by 0 yields all-ones q).

## Structure
- Shared package: FSM state enum, DIGITS localparam function, and the width-legality constant check.
- One sub-module, rans_divider: start/busy/done, sequential restoring divider returning q and r. The top-level FSM, multiplier-adder and digit mux stay in rans_encoder.

## Test plan
All cases use the defaults (16/8/4).
- Reset, M=16; encode f=4,c=0 -> no digit, x=64, in_rdy back 19 cycles after accept.
- Then f=4,c=4 -> one digit 0x0, then x=20.
- Then f=4,c=4,in_last=1 -> no renorm digit, x=(20/4)·16+4+0=84, flush digits 0x4,0x5,0x0,0x0 with out_last on the 4th, then x=16.
- Hold out_rdy=0 for 5 cycles during a flush -> out, out_last and out_vld stable; digit sequence unchanged.
- Assert rst mid-DIV -> next cycle in_rdy=1, out_vld=0, and the following encode starts from x=M.
- With ANS_ENC_ERR_EN, f=0 -> err=1 for one cycle, no digit, x unchanged, in_rdy stays 1. With ena toggling every cycle, the result matches the ena=1 case.
